// File: rtl/ysyx_25010008_bus_pkg.sv
// Shared types and constants for the round-robin AXI-lite arbiter.
// DRAIN only exists when YSYX_25010008_ARB_TIMEOUT_EN is defined.
package ysyx_25010008_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RADDR,
    RDATA,
    WADDR,
    WRESP
`ifdef YSYX_25010008_ARB_TIMEOUT_EN
    , DRAIN
`endif
  } arb_state_e;

  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/ysyx_25010008_rr_pick.sv
// Round-robin pick: first set req bit scanning from ptr+1 upward, modulo N_MST.
// Purely combinational; any flags that at least one request is present.
module ysyx_25010008_rr_pick #(
  parameter int N_MST = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_MST-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    // Walk farthest-first so the nearest requester after ptr is the last writer.
    for (int k = N_MST; k >= 1; k--) begin
      idx = IDX_W'((int'(ptr) + k) % N_MST);
      if (req[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_25010008_rr_arbiter.sv
// Round-robin AXI-lite arbiter: N_MST masters share one slave, one transaction in flight.
// YSYX_25010008_ARB_TIMEOUT_EN adds a response timeout with error reply and slave drain.
module ysyx_25010008_rr_arbiter
  import ysyx_25010008_bus_pkg::*;
#(
  parameter int N_MST  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef YSYX_25010008_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_MST-1:0]          m_arvalid,
  input  logic [N_MST*ADDR_W-1:0]   m_araddr,
  output logic [N_MST-1:0]          m_arready,
  output logic [N_MST-1:0]          m_rvalid,
  input  logic [N_MST-1:0]          m_rready,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_rresp,
  input  logic [N_MST-1:0]          m_awvalid,
  input  logic [N_MST*ADDR_W-1:0]   m_awaddr,
  output logic [N_MST-1:0]          m_awready,
  input  logic [N_MST-1:0]          m_wvalid,
  input  logic [N_MST*DATA_W-1:0]   m_wdata,
  input  logic [N_MST*DATA_W/8-1:0] m_wstrb,
  output logic [N_MST-1:0]          m_wready,
  output logic [N_MST-1:0]          m_bvalid,
  input  logic [N_MST-1:0]          m_bready,
  output logic                      m_bresp,
  output logic                      s_arvalid,
  output logic [ADDR_W-1:0]         s_araddr,
  input  logic                      s_arready,
  input  logic                      s_rvalid,
  output logic                      s_rready,
  input  logic [DATA_W-1:0]         s_rdata,
  input  logic                      s_rresp,
  output logic                      s_awvalid,
  output logic [ADDR_W-1:0]         s_awaddr,
  input  logic                      s_awready,
  output logic                      s_wvalid,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [DATA_W/8-1:0]       s_wstrb,
  input  logic                      s_wready,
  input  logic                      s_bvalid,
  output logic                      s_bready,
  input  logic                      s_bresp
);

  localparam int IDX_W  = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int STRB_W = DATA_W / 8;

  arb_state_e       state_q;
  logic [IDX_W-1:0] gnt_q, ptr_q, pick_gnt;
  logic             pick_any;
  logic             aw_done_q, w_done_q;
  logic             aw_done_d, w_done_d;
  logic             tmo, rsp_fire;

  ysyx_25010008_rr_pick #(.N_MST(N_MST), .IDX_W(IDX_W)) u_pick (
    .req (m_arvalid | (m_awvalid & m_wvalid)),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .any (pick_any)
  );

`ifdef YSYX_25010008_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             slv_vld;
  assign tmo     = (state_q == RDATA || state_q == WRESP) && (cnt_q == CNT_W'(TIMEOUT_CYC));
  assign slv_vld = (state_q == RDATA) ? s_rvalid : s_bvalid;
`else
  assign tmo = 1'b0;
`endif

  assign aw_done_d = aw_done_q | (s_awvalid & s_awready);
  assign w_done_d  = w_done_q  | (s_wvalid  & s_wready);
  assign rsp_fire  = ((state_q == RDATA) && m_rvalid[gnt_q] && m_rready[gnt_q]) ||
                     ((state_q == WRESP) && m_bvalid[gnt_q] && m_bready[gnt_q]);

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_rdata   = s_rdata;
    m_rresp   = s_rresp;
    m_bresp   = s_bresp;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b0;
    s_araddr  = m_araddr[int'(gnt_q)*ADDR_W +: ADDR_W];
    s_awaddr  = m_awaddr[int'(gnt_q)*ADDR_W +: ADDR_W];
    s_wdata   = m_wdata[int'(gnt_q)*DATA_W +: DATA_W];
    s_wstrb   = m_wstrb[int'(gnt_q)*STRB_W +: STRB_W];
    unique case (state_q)
      RADDR: begin
        s_arvalid        = 1'b1;
        m_arready[gnt_q] = s_arready;
      end
      RDATA: begin
        if (tmo) begin
          m_rvalid[gnt_q] = 1'b1;
          m_rdata         = '0;
          m_rresp         = RESP_ERR;
        end else begin
          m_rvalid[gnt_q] = s_rvalid;
          s_rready        = m_rready[gnt_q];
        end
      end
      WADDR: begin
        s_awvalid        = !aw_done_q;
        s_wvalid         = !w_done_q;
        m_awready[gnt_q] = s_awready & !aw_done_q;
        m_wready[gnt_q]  = s_wready & !w_done_q;
      end
      WRESP: begin
        if (tmo) begin
          m_bvalid[gnt_q] = 1'b1;
          m_bresp         = RESP_ERR;
        end else begin
          m_bvalid[gnt_q] = s_bvalid;
          s_bready        = m_bready[gnt_q];
        end
      end
`ifdef YSYX_25010008_ARB_TIMEOUT_EN
      DRAIN: begin
        s_rready = 1'b1;
        s_bready = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ptr_q     <= IDX_W'(N_MST - 1);
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
`ifdef YSYX_25010008_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: if (pick_any) begin
          gnt_q   <= pick_gnt;
          // Read wins when the chosen master offers both.
          state_q <= m_arvalid[pick_gnt] ? RADDR : WADDR;
        end
        RADDR: if (s_arready) state_q <= RDATA;
        WADDR: begin
          if (aw_done_d && w_done_d) begin
            state_q   <= WRESP;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
          end
        end
        RDATA, WRESP: if (rsp_fire) begin
          ptr_q <= gnt_q;
`ifdef YSYX_25010008_ARB_TIMEOUT_EN
          state_q <= tmo ? DRAIN : IDLE;
`else
          state_q <= IDLE;
`endif
        end
`ifdef YSYX_25010008_ARB_TIMEOUT_EN
        DRAIN: if (s_rvalid || s_bvalid || cnt_q == CNT_W'(TIMEOUT_CYC - 1)) state_q <= IDLE;
`endif
        default: state_q <= IDLE;
      endcase
`ifdef YSYX_25010008_ARB_TIMEOUT_EN
      if (state_q == RDATA || state_q == WRESP) begin
        if (rsp_fire || (slv_vld && !tmo)) cnt_q <= '0;
        else if (!tmo)                     cnt_q <= cnt_q + CNT_W'(1);
      end else if (state_q == DRAIN) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_25010008_rr_arbiter.sv
// Directed bench for the round-robin AXI-lite arbiter with two masters.
module tb_ysyx_25010008_rr_arbiter;

  localparam int N = 2, AW = 32, DW = 32, SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N*AW-1:0] m_araddr, m_awaddr;
  logic [DW-1:0]   m_rdata;
  logic            m_rresp, m_bresp;
  logic [N-1:0]    m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic            s_arvalid, s_arready, s_rvalid, s_rready, s_rresp;
  logic [AW-1:0]   s_araddr, s_awaddr;
  logic [DW-1:0]   s_rdata, s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic            s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready, s_bresp;

  int vec = 0;
  int err = 0;

  logic [14:0] vr_all;
  assign vr_all = {m_arready, m_rvalid, m_awready, m_wready, m_bvalid,
                   s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready};

  always #5 clk = ~clk;

  ysyx_25010008_rr_arbiter #(
    .N_MST(N), .ADDR_W(AW), .DATA_W(DW)
`ifdef YSYX_25010008_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
  );

  task automatic clr_inputs();
    m_arvalid = '0; m_araddr = '0; m_rready = '0;
    m_awvalid = '0; m_awaddr = '0; m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_bready = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 1'b0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 2 units later.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_inputs();
    rst = 1'b1;
    nxt(); nxt();
    rst = 1'b0;
    #2;
    vec++;
    if (vr_all !== 15'h0) begin err++; $display("FAIL reset_outputs: got %h want 0000", vr_all); end
  endtask

  task automatic test_simul_reads();
    nxt();
    m_arvalid = 2'b11; m_araddr = {32'h8000_0004, 32'h8000_0000}; m_rready = 2'b11; s_arready = 1'b1;
    #2;
    vec++;
    if (s_arvalid !== 1'b0) begin err++; $display("FAIL arb_latency: s_arvalid=%b want 0", s_arvalid); end
    nxt(); #2;
    vec++;
    if ({s_arvalid, s_araddr, m_arready} !== {1'b1, 32'h8000_0000, 2'b01}) begin
      err++; $display("FAIL rd0_addr: got %b %h %b want 1 80000000 01", s_arvalid, s_araddr, m_arready);
    end
    nxt();
    m_arvalid = 2'b10; s_rvalid = 1'b1; s_rdata = 32'h1111_1111; s_rresp = 1'b0;
    #2;
    vec++;
    if ({m_rvalid, m_rdata, m_rresp} !== {2'b01, 32'h1111_1111, 1'b0}) begin
      err++; $display("FAIL rd0_data: got %b %h %b want 01 11111111 0", m_rvalid, m_rdata, m_rresp);
    end
    nxt(); s_rvalid = 1'b0; #2;
    nxt(); #2;
    vec++;
    if ({s_araddr, m_arready} !== {32'h8000_0004, 2'b10}) begin
      err++; $display("FAIL rd1_addr: got %h %b want 80000004 10", s_araddr, m_arready);
    end
    nxt();
    m_arvalid = 2'b00; s_rvalid = 1'b1; s_rdata = 32'h2222_2222; s_rresp = 1'b1;
    #2;
    vec++;
    if ({m_rvalid, m_rdata, m_rresp} !== {2'b10, 32'h2222_2222, 1'b1}) begin
      err++; $display("FAIL rd1_data: got %b %h %b want 10 22222222 1", m_rvalid, m_rdata, m_rresp);
    end
    nxt(); s_rvalid = 1'b0; s_rresp = 1'b0; m_arvalid = 2'b11; #2;
    nxt(); #2;
    vec++;
    if ({s_araddr, m_arready} !== {32'h8000_0000, 2'b01}) begin
      err++; $display("FAIL ptr_after_reads: got %h %b want 80000000 01", s_araddr, m_arready);
    end
    nxt(); m_arvalid = 2'b00; s_rvalid = 1'b1; #2;
    nxt(); s_rvalid = 1'b0; s_arready = 1'b0; m_rready = 2'b00; #2;
  endtask

  task automatic test_write_delayed_aw();
    int  aw_n = 0, w_n = 0;
    logic aw_f = 1'b0, w_f = 1'b0;
    nxt();
    m_awvalid = 2'b10; m_wvalid = 2'b10;
    m_awaddr = {32'hA000_0000, 32'h0}; m_wdata = {32'hDEAD_BEEF, 32'h0}; m_wstrb = {4'hF, 4'h0};
    m_bready = 2'b10; s_awready = 1'b0; s_wready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      nxt();
      if (aw_f) m_awvalid = 2'b00;
      if (w_f)  m_wvalid  = 2'b00;
      aw_f = 1'b0; w_f = 1'b0;
      s_awready = (k >= 3);
      #2;
      if (k == 0) begin
        vec++;
        if ({m_awready, m_wready} !== 4'b0010) begin
          err++; $display("FAIL wr_first_ready: got aw=%b w=%b want aw=00 w=10", m_awready, m_wready);
        end
      end
      if (s_awvalid && s_awready) begin
        aw_n++; aw_f = 1'b1;
        vec++;
        if ({s_awaddr, m_awready} !== {32'hA000_0000, 2'b10}) begin
          err++; $display("FAIL wr_aw_route: got %h %b want a0000000 10", s_awaddr, m_awready);
        end
      end
      if (s_wvalid && s_wready) begin
        w_n++; w_f = 1'b1;
        vec++;
        if ({s_wdata, s_wstrb, m_wready} !== {32'hDEAD_BEEF, 4'hF, 2'b10}) begin
          err++; $display("FAIL wr_w_route: got %h %h %b want deadbeef f 10", s_wdata, s_wstrb, m_wready);
        end
      end
    end
    vec++;
    if (aw_n != 1 || w_n != 1) begin
      err++; $display("FAIL wr_hs_count: got aw=%0d w=%0d want aw=1 w=1", aw_n, w_n);
    end
    vec++;
    if ({m_bvalid, s_bready, s_awvalid, s_wvalid} !== 5'b00100) begin
      err++; $display("FAIL wr_wait_b: got bv=%b br=%b awv=%b wv=%b want 00 1 0 0", m_bvalid, s_bready, s_awvalid, s_wvalid);
    end
    nxt(); m_awvalid = 2'b00; m_wvalid = 2'b00; s_bvalid = 1'b1; s_bresp = 1'b0; #2;
    vec++;
    if ({m_bvalid, m_bresp} !== {2'b10, 1'b0}) begin
      err++; $display("FAIL wr_bresp: got %b %b want 10 0", m_bvalid, m_bresp);
    end
    nxt(); s_bvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0; m_bready = 2'b00; #2;
    vec++;
    if (vr_all !== 15'h0) begin err++; $display("FAIL wr_back_idle: got %h want 0000", vr_all); end
  endtask

  task automatic test_read_before_write();
    nxt();
    m_arvalid = 2'b01; m_awvalid = 2'b01; m_wvalid = 2'b01;
    m_araddr = {32'h0, 32'h8000_0010}; m_awaddr = {32'h0, 32'h9000_0000};
    m_wdata = {32'h0, 32'h1234_5678}; m_wstrb = {4'h0, 4'h3};
    m_rready = 2'b01; m_bready = 2'b01; s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
    #2;
    nxt(); #2;
    vec++;
    if ({s_arvalid, s_awvalid, s_wvalid, s_araddr} !== {3'b100, 32'h8000_0010}) begin
      err++; $display("FAIL rw_read_first: got ar=%b aw=%b w=%b %h want 1 0 0 80000010", s_arvalid, s_awvalid, s_wvalid, s_araddr);
    end
    nxt(); m_arvalid = 2'b00; s_rvalid = 1'b1; s_rdata = 32'h3333_3333; #2;
    vec++;
    if ({m_rvalid, s_awvalid, m_rdata} !== {2'b01, 1'b0, 32'h3333_3333}) begin
      err++; $display("FAIL rw_rdata: got rv=%b awv=%b %h want 01 0 33333333", m_rvalid, s_awvalid, m_rdata);
    end
    nxt(); s_rvalid = 1'b0; #2;
    nxt(); #2;
    vec++;
    if ({s_awvalid, s_wvalid, s_awaddr, s_wstrb, m_awready, m_wready} !== {2'b11, 32'h9000_0000, 4'h3, 2'b01, 2'b01}) begin
      err++; $display("FAIL rw_write_grant: got %b %b %h %h %b %b want 1 1 90000000 3 01 01", s_awvalid, s_wvalid, s_awaddr, s_wstrb, m_awready, m_wready);
    end
    nxt(); m_awvalid = 2'b00; m_wvalid = 2'b00; s_bvalid = 1'b1; s_bresp = 1'b1; #2;
    vec++;
    if ({s_awvalid, s_wvalid, m_bvalid, m_bresp} !== {2'b00, 2'b01, 1'b1}) begin
      err++; $display("FAIL rw_same_cycle_hs: got awv=%b wv=%b bv=%b bresp=%b want 0 0 01 1", s_awvalid, s_wvalid, m_bvalid, m_bresp);
    end
    nxt(); clr_inputs(); #2;
  endtask

  task automatic test_reset_in_rdata();
    nxt();
    m_arvalid = 2'b10; m_araddr = {32'h8000_0020, 32'h8000_0030}; m_rready = 2'b11; s_arready = 1'b1;
    #2;
    nxt(); #2;
    nxt(); m_arvalid = 2'b11; #2;
    vec++;
    if ({s_rready, m_rvalid} !== 3'b100) begin
      err++; $display("FAIL rst_mid_in_rdata: got rr=%b rv=%b want 1 00", s_rready, m_rvalid);
    end
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    #2;
    vec++;
    if (vr_all !== 15'h0) begin err++; $display("FAIL rst_mid_outputs: got %h want 0000", vr_all); end
    nxt(); #2;
    vec++;
    if ({s_arvalid, s_araddr, m_arready} !== {1'b1, 32'h8000_0030, 2'b01}) begin
      err++; $display("FAIL rst_mid_regrant: got %b %h %b want 1 80000030 01", s_arvalid, s_araddr, m_arready);
    end
    clr_inputs();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

`ifdef YSYX_25010008_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int drain_bad = 0;
    nxt();
    m_arvalid = 2'b01; m_araddr = {32'h0, 32'h8000_0040}; m_rready = 2'b01; s_arready = 1'b1;
    s_rdata = 32'hFFFF_FFFF;
    #2;
    nxt(); #2;
    for (int c = 1; c <= 9; c++) begin
      nxt(); m_arvalid = 2'b00; #2;
      vec++;
      if (c < 9 && m_rvalid !== 2'b00) begin
        err++; $display("FAIL tmo_early: cycle %0d rvalid=%b want 00", c, m_rvalid);
      end else if (c == 9 && {m_rvalid, m_rdata, m_rresp} !== {2'b01, 32'h0, 1'b1}) begin
        err++; $display("FAIL tmo_err_rsp: got %b %h %b want 01 00000000 1", m_rvalid, m_rdata, m_rresp);
      end
    end
    for (int d = 1; d <= 8; d++) begin
      nxt(); #2;
      if ({s_rready, s_bready, m_rvalid} !== 4'b1100) drain_bad++;
    end
    vec++;
    if (drain_bad != 0) begin err++; $display("FAIL tmo_drain: %0d bad cycles want 0", drain_bad); end
    nxt(); #2;
    vec++;
    if (vr_all !== 15'h0) begin err++; $display("FAIL tmo_back_idle: got %h want 0000", vr_all); end
    clr_inputs();
  endtask
`endif

  initial begin
    rst = 1'b1;
    clr_inputs();
    test_reset();
    test_simul_reads();
    test_write_delayed_aw();
    test_read_before_write();
    test_reset_in_rdata();
`ifdef YSYX_25010008_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
